// File: rtl/mem_request_unit.sv
// Load/store request sequencer between the execute stage and a data memory.
// Runs one access at a time through IDLE -> REQ -> DONE, with a bounded wait for memAck.
module mem_request_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        isLd,
    input  logic        isSt,
    input  logic [31:0] aluResult,
    input  logic [31:0] op2,
    output logic        stall,
    output logic [31:0] ldResult,
    output logic        ldValid,
    output logic        memReq,
    output logic        memWe,
    output logic [7:0]  memAddr,
    output logic [31:0] memWdata,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        memErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value seen during the last permitted REQ cycle.
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_result_q, ld_result_d;
    logic        err_q, err_d;

    logic cmd;
    logic unused_addr_hi;

    assign cmd            = isLd | isSt;
    assign unused_addr_hi = ^aluResult[31:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 8'd0;
            wdata_q     <= 32'd0;
            ld_result_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ld_result_q <= ld_result_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ld_result_d = ld_result_q;
        err_d       = err_q;
        stall       = 1'b0;
        ldValid     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd) begin
                    stall   = 1'b1;
                    addr_d  = aluResult[7:0];
                    wdata_d = op2;
                    we_d    = isSt & ~isLd;
                    wait_d  = 4'd0;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                // An ack in the final permitted cycle still wins over the timeout.
                if (memAck) begin
                    if (!we_q) begin
                        ld_result_d = memRdata;
                    end
                    state_d = DONE;
                end else if (wait_q == TIMEOUT_LAST) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        ld_result_d = 32'd0;
                    end
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DONE: begin
                ldValid = ~we_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign memReq   = (state_q == REQ);
    assign memWe    = we_q;
    assign memAddr  = addr_q;
    assign memWdata = wdata_q;
    assign ldResult = ld_result_q;
    assign memErr   = err_q;

endmodule
